// File: rtl/pipeline_seq_mc.sv
// Multi-lane pipeline sequencer: buffers sample frames in a small FIFO, issues each lane
// to the shared DSP core with a tick/ready handshake and gathers the results per frame.
module pipeline_seq_mc #(
  parameter int data_width     = 16,
  parameter int n_lanes        = 2,
  parameter int fifo_depth     = 4,
  parameter int timeout_cycles = 4096,
  parameter int ctr_width      = 32,
  localparam int lane_w  = (n_lanes > 1) ? $clog2(n_lanes) : 1,
  localparam int frame_w = n_lanes * data_width
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [frame_w-1:0]    in_frame,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  core_tick,
  output logic [data_width-1:0] core_sample,
  output logic [lane_w-1:0]     core_lane,
  input  logic                  core_ready,
  input  logic [data_width-1:0] core_result,
  output logic [frame_w-1:0]    out_frame,
  output logic                  out_valid,
  output logic [ctr_width-1:0]  frame_ctr,
  output logic [ctr_width-1:0]  overrun_ctr,
  output logic                  overrun,
  output logic                  error,
  input  logic                  clear_error,
  output logic [2:0]            dbg_state
);
  localparam int ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int tmr_w = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [tmr_w-1:0] tmr_max = tmr_w'(timeout_cycles - 1);
  localparam logic [ptr_w:0]   cnt_full = (ptr_w + 1)'(fifo_depth);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [frame_w-1:0]    mem_q [fifo_depth];
  logic [ptr_w-1:0]      wr_ptr_q, rd_ptr_q;
  logic [ptr_w:0]        count_q, count_d;
  logic                  in_ready_q;
  logic [frame_w-1:0]    work_q;
  logic [lane_w-1:0]     lane_q;
  logic [tmr_w-1:0]      timer_q;
  logic [frame_w-1:0]    res_q, res_d;
  logic [frame_w-1:0]    out_frame_q;
  logic                  out_valid_q;
  logic [ctr_width-1:0]  frame_ctr_q, overrun_ctr_q;
  logic                  overrun_q, error_q;

  logic fifo_empty, fifo_full, push_req, push_ok, drop, pop;
  logic wait_hit, timeout_hit, lane_last;

  // Input side: a frame is taken on any cycle with in_valid high and in_ready high;
  // in_valid with in_ready low drops the frame unless the FIFO pops in that same cycle.
  // Core side: core_tick starts one lane, core_ready high in WAIT returns its result.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == cnt_full);
  assign push_req   = in_valid && !clear_error;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;
  assign lane_last  = (lane_q == lane_w'(n_lanes - 1));

  always_comb begin
    count_d = count_q;
    if (clear_error)          count_d = '0;
    else if (push_ok && !pop) count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
  end

  always_comb begin
    res_d = res_q;
    if (wait_hit) res_d[int'(lane_q)*data_width +: data_width] = core_result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_ISSUE;
      S_ISSUE: state_d = S_ARM;
      S_ARM:   state_d = S_WAIT;
      S_WAIT: begin
        if (wait_hit)         state_d = lane_last ? S_DONE : S_ISSUE;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (clear_error) state_d = S_IDLE;
  end

  always_comb begin
    core_tick   = 1'b0;
    pop         = 1'b0;
    wait_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE:  pop = !fifo_empty && !clear_error;
      S_ISSUE: core_tick = 1'b1;
      S_WAIT: begin
        wait_hit    = core_ready;
        timeout_hit = !core_ready && (timer_q == tmr_max);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= in_frame;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b1;
      work_q        <= '0;
      lane_q        <= '0;
      timer_q       <= '0;
      res_q         <= '0;
      out_frame_q   <= '0;
      out_valid_q   <= 1'b0;
      frame_ctr_q   <= '0;
      overrun_ctr_q <= '0;
      overrun_q     <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      in_ready_q  <= (count_d != cnt_full);
      out_valid_q <= 1'b0;
      if (clear_error) begin
        wr_ptr_q      <= '0;
        rd_ptr_q      <= '0;
        error_q       <= 1'b0;
        overrun_q     <= 1'b0;
        overrun_ctr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          work_q   <= mem_q[rd_ptr_q];
          lane_q   <= '0;
        end
        if (drop) begin
          overrun_q <= 1'b1;
          if (overrun_ctr_q != '1) overrun_ctr_q <= overrun_ctr_q + 1'b1;
        end
        if (timeout_hit) error_q <= 1'b1;
        if (state_q == S_ARM) timer_q <= '0;
        else if ((state_q == S_WAIT) && !core_ready && !timeout_hit) timer_q <= timer_q + 1'b1;
        res_q <= res_d;
        // The output frame is published on entry to DONE so it is valid with out_valid.
        if (wait_hit) begin
          if (lane_last) begin
            out_frame_q <= res_d;
            out_valid_q <= 1'b1;
            frame_ctr_q <= frame_ctr_q + 1'b1;
          end else begin
            lane_q <= lane_q + 1'b1;
          end
        end
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign core_sample = work_q[int'(lane_q)*data_width +: data_width];
  assign core_lane   = lane_q;
  assign out_frame   = out_frame_q;
  assign out_valid   = out_valid_q;
  assign frame_ctr   = frame_ctr_q;
  assign overrun_ctr = overrun_ctr_q;
  assign overrun     = overrun_q;
  assign error       = error_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipeline_seq_mc.sv
// Bench for pipeline_seq_mc: a 2-lane instance driven against a reactive core model with a
// frame scoreboard, plus a 4-lane 24-bit instance exercising lane order and packing.
module tb_pipeline_seq_mc;
  localparam int DW  = 16;
  localparam int NL  = 2;
  localparam int FW  = NL * DW;
  localparam int TMO = 32;
  localparam int DW4 = 24;
  localparam int NL4 = 4;
  localparam int FW4 = NL4 * DW4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [FW-1:0] in_frame;
  logic          in_valid, in_ready, core_tick, core_ready, out_valid;
  logic          overrun, error, clear_error;
  logic [DW-1:0] core_sample, core_result;
  logic [0:0]    core_lane;
  logic [FW-1:0] out_frame;
  logic [31:0]   frame_ctr, overrun_ctr;
  logic [2:0]    dbg_state;

  logic [FW4-1:0] f4, out4;
  logic           v4, rdy4, tick4, ready4, ov4, ovr4, err4;
  logic [DW4-1:0] sample4, result4;
  logic [1:0]     lane4;
  logic [31:0]    fctr4, octr4;
  logic [2:0]     st4;

  int n_checks = 0;
  int n_fail = 0;
  logic [FW-1:0] exp_q[$];
  int ov_hist[$];
  int lane4_q[$];
  int cyc = 0;
  int push_cyc = 0;
  int tick_cnt = 0;
  int wait_run = 0;
  int exp_frames = 0;
  int lat_min = 0;
  int lat_max = 0;
  int busy = 0;
  bit stall = 1'b0;

  pipeline_seq_mc #(.data_width(DW), .n_lanes(NL), .fifo_depth(4), .timeout_cycles(TMO), .ctr_width(32)) u_dut (
    .clk(clk), .reset(reset), .in_frame(in_frame), .in_valid(in_valid), .in_ready(in_ready),
    .core_tick(core_tick), .core_sample(core_sample), .core_lane(core_lane),
    .core_ready(core_ready), .core_result(core_result), .out_frame(out_frame),
    .out_valid(out_valid), .frame_ctr(frame_ctr), .overrun_ctr(overrun_ctr),
    .overrun(overrun), .error(error), .clear_error(clear_error), .dbg_state(dbg_state)
  );

  pipeline_seq_mc #(.data_width(DW4), .n_lanes(NL4), .fifo_depth(4), .timeout_cycles(4096), .ctr_width(32)) u_dut4 (
    .clk(clk), .reset(reset), .in_frame(f4), .in_valid(v4), .in_ready(rdy4),
    .core_tick(tick4), .core_sample(sample4), .core_lane(lane4),
    .core_ready(ready4), .core_result(result4), .out_frame(out4),
    .out_valid(ov4), .frame_ctr(fctr4), .overrun_ctr(octr4),
    .overrun(ovr4), .error(err4), .clear_error(clear_error), .dbg_state(st4)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // core models: echo sample+1 after a random busy time
  always @(negedge clk) begin
    if (!reset) begin
      busy = 0;
      core_ready = !stall;
    end else if (core_tick) begin
      busy = $urandom_range(lat_max, lat_min);
      core_result = core_sample + 16'd1;
      core_ready = (busy == 0) && !stall;
    end else begin
      if (busy > 0) busy--;
      core_ready = (busy == 0) && !stall;
    end
  end

  always @(negedge clk) begin
    if (reset && tick4) begin
      result4 = sample4 + 24'd1;
      lane4_q.push_back(int'(lane4));
    end
  end

  // monitors and scoreboard
  always @(negedge clk) begin
    if (reset && core_tick) tick_cnt++;
    if (dbg_state == 3'd3) wait_run++;
    else if (dbg_state != 3'd5) wait_run = 0;
  end

  always @(negedge clk) begin
    if (reset && out_valid) begin
      ov_hist.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", out_valid, 1'b0);
      end else begin
        check("out_frame", out_frame, exp_q.pop_front());
      end
      exp_frames++;
      check("frame_ctr", frame_ctr, exp_frames);
    end
  end

  // driver tasks (called at a negedge, return at a later negedge)
  task automatic push_frame(input logic [FW-1:0] f, input bit expect_ok);
    logic [FW-1:0] e;
    for (int k = 0; k < NL; k++) e[k*DW +: DW] = f[k*DW +: DW] + 16'd1;
    in_frame = f;
    in_valid = 1'b1;
    push_cyc = cyc;
    if (expect_ok) exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || dbg_state != 3'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < budget, 1'b1);
  endtask

  initial begin
    int p, t0, n;
    bit found;
    logic [FW4-1:0] e4;
    in_valid = 1'b0; in_frame = '0; clear_error = 1'b0;
    core_ready = 1'b1; core_result = '0;
    v4 = 1'b0; f4 = '0; ready4 = 1'b1; result4 = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_core_tick", core_tick, 1'b0);
    check("rst_out_frame", out_frame, 0);
    check("rst_frame_ctr", frame_ctr, 0);
    check("rst_overrun_ctr", overrun_ctr, 0);
    check("rst_flags", {overrun, error}, 2'b00);
    check("rst_state", dbg_state, 3'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // basic frame
    t0 = tick_cnt;
    ov_hist.delete();
    push_frame(32'h0010_0020, 1'b1);
    p = push_cyc;
    drain("basic_drain", 50);
    check("basic_ticks", tick_cnt - t0, 2);
    check("basic_ov_count", ov_hist.size(), 1);
    if (ov_hist.size() > 0) check("basic_latency", ov_hist[0] - p, 3*NL + 2);
    repeat (3) @(negedge clk);
    check("basic_hold", out_frame, 32'h0011_0021);

    // 4-lane 24-bit build
    f4 = {$urandom, $urandom, $urandom};
    for (int k = 0; k < NL4; k++) e4[k*DW4 +: DW4] = f4[k*DW4 +: DW4] + 24'd1;
    v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (ov4) found = 1'b1;
    end
    check("l4_done", found, 1'b1);
    check("l4_out_frame", out4, e4);
    check("l4_tick_count", lane4_q.size(), NL4);
    for (int k = 0; k < NL4 && k < lane4_q.size(); k++) check("l4_lane_order", lane4_q[k], k);

    // back-to-back
    lat_min = 0; lat_max = 0;
    ov_hist.delete();
    for (int i = 0; i < 4; i++) push_frame(FW'({$urandom}), 1'b1);
    drain("b2b_drain", 100);
    check("b2b_count", ov_hist.size(), 4);
    for (int i = 1; i < ov_hist.size(); i++) check("b2b_spacing", ov_hist[i] - ov_hist[i-1], 3*NL + 2);
    check("b2b_overrun_ctr", overrun_ctr, 0);

    // random traffic with variable core latency, pushes only when in_ready
    lat_max = 4;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      check("rnd_in_ready_wait", n < 200, 1'b1);
      push_frame(FW'({$urandom}), 1'b1);
    end
    drain("rnd_drain", 2000);
    check("rnd_overrun", overrun, 1'b0);

    // overrun then watchdog
    lat_max = 0;
    stall = 1'b1;
    repeat (2) @(negedge clk);
    t0 = tick_cnt;
    for (int i = 0; i < 6; i++) push_frame(FW'({$urandom}), 1'b0);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_ctr", overrun_ctr, 1);
    check("ovr_in_ready", in_ready, 1'b0);
    check("ovr_state_wait", dbg_state, 3'd3);
    check("ovr_ticks", tick_cnt - t0, 1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (error) found = 1'b1;
    end
    check("wd_error", error, 1'b1);
    check("wd_wait_cycles", wait_run, TMO);
    check("wd_state_fault", dbg_state, 3'd5);
    t0 = tick_cnt;
    repeat (10) @(negedge clk);
    check("wd_no_tick", tick_cnt - t0, 0);
    push_frame(FW'({$urandom}), 1'b0);
    check("wd_drop_ctr", overrun_ctr, 2);
    stall = 1'b0;
    clear_error = 1'b1;
    in_valid = 1'b1;
    in_frame = FW'({$urandom});
    @(negedge clk);
    clear_error = 1'b0;
    in_valid = 1'b0;
    check("clr_error", error, 1'b0);
    check("clr_overrun", overrun, 1'b0);
    check("clr_overrun_ctr", overrun_ctr, 0);
    check("clr_state", dbg_state, 3'd0);
    t0 = tick_cnt;
    repeat (10) @(negedge clk);
    check("clr_fifo_empty", tick_cnt - t0, 0);
    check("clr_in_ready", in_ready, 1'b1);
    push_frame(32'h1234_ABCD, 1'b1);
    drain("clr_next_drain", 100);

    // reset during lane 1 WAIT
    lat_min = 4; lat_max = 4;
    push_frame(FW'({$urandom}), 1'b1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (dbg_state == 3'd3 && core_lane == 1'b1) found = 1'b1;
    end
    check("rm_reach_lane1", found, 1'b1);
    reset = 1'b0;
    #1;
    check("rm_in_ready", in_ready, 1'b1);
    check("rm_outputs", {out_valid, core_tick, core_lane, core_sample, overrun, error}, 0);
    check("rm_out_frame", out_frame, 0);
    check("rm_counters", {frame_ctr, overrun_ctr}, 0);
    check("rm_state", dbg_state, 3'd0);
    exp_q.delete();
    exp_frames = 0;
    lat_min = 0; lat_max = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ov_hist.delete();
    repeat (30) @(negedge clk);
    check("rm_no_out_valid", ov_hist.size(), 0);
    push_frame(32'hFFFF_7FFF, 1'b1);
    drain("rm_next_drain", 100);
    check("rm_next_out", out_frame, 32'h0000_8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
